// File: rtl/pc_stack_unit.sv
// Program counter with a 2-entry hardware return stack for a PIC16C5x-style core.
// Optional sticky stack overflow/underflow flag (stackErr) when PC_STACK_ERR_EN is defined.
module pc_stack_unit #(
    parameter int unsigned PC_WIDTH    = 9,
    parameter int unsigned STACK_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                gotoEn,
    input  logic                callEn,
    input  logic                retEn,
    input  logic                pclWrEn,
    input  logic [8:0]          instAddr,
    input  logic [7:0]          pclData,
`ifdef PC_STACK_ERR_EN
    output logic                stackErr,
`endif
    output logic [PC_WIDTH-1:0] PCOut,
    output logic                flushOut
);

    localparam logic [1:0] DepthMax = 2'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
    logic [PC_WIDTH-1:0] stack1_q, stack1_d;
    logic [PC_WIDTH-1:0] stack2_q, stack2_d;
    logic [1:0]          depth_q, depth_d;
    logic                flush_q, flush_d;

    // Priority: ret > call > goto > PCL write > increment.
    always_comb begin
        pc_inc   = pc_q + PC_WIDTH'(1);
        pc_d     = pc_inc;
        stack1_d = stack1_q;
        stack2_d = stack2_q;
        depth_d  = depth_q;
        flush_d  = 1'b0;
        if (retEn) begin
            pc_d     = stack1_q;
            stack1_d = stack2_q;
            flush_d  = 1'b1;
            if (depth_q != 2'd0) depth_d = depth_q - 2'd1;
        end else if (callEn) begin
            pc_d     = PC_WIDTH'(instAddr[7:0]);
            stack1_d = pc_inc;
            stack2_d = stack1_q;
            flush_d  = 1'b1;
            if (depth_q != DepthMax) depth_d = depth_q + 2'd1;
        end else if (gotoEn) begin
            pc_d    = PC_WIDTH'(instAddr);
            flush_d = 1'b1;
        end else if (pclWrEn) begin
            pc_d    = PC_WIDTH'(pclData);
            flush_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '1;
            stack1_q <= '0;
            stack2_q <= '0;
            depth_q  <= 2'd0;
            flush_q  <= 1'b0;
        end else if (en) begin
            pc_q     <= pc_d;
            stack1_q <= stack1_d;
            stack2_q <= stack2_d;
            depth_q  <= depth_d;
            flush_q  <= flush_d;
        end
    end

`ifdef PC_STACK_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (retEn && depth_q == 2'd0) err_d = 1'b1;
        if (!retEn && callEn && depth_q == DepthMax) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (en) begin
            err_q <= err_d;
        end
    end

    assign stackErr = err_q;
`endif

    assign PCOut    = pc_q;
    assign flushOut = flush_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed self-checking bench for pc_stack_unit; checks stackErr when PC_STACK_ERR_EN is defined.
module tb_pc_stack_unit;

    logic       clk, rst_n, en, gotoEn, callEn, retEn, pclWrEn;
    logic [8:0] instAddr;
    logic [7:0] pclData;
    logic [8:0] PCOut;
    logic       flushOut;
`ifdef PC_STACK_ERR_EN
    logic       stackErr;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pc_stack_unit #(.PC_WIDTH(9), .STACK_DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .gotoEn   (gotoEn),
        .callEn   (callEn),
        .retEn    (retEn),
        .pclWrEn  (pclWrEn),
        .instAddr (instAddr),
        .pclData  (pclData),
`ifdef PC_STACK_ERR_EN
        .stackErr (stackErr),
`endif
        .PCOut    (PCOut),
        .flushOut (flushOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        gotoEn = 0; callEn = 0; retEn = 0; pclWrEn = 0;
    endtask

    task automatic test_reset();
        logic [8:0] exp_pc[3] = '{9'h000, 9'h001, 9'h002};
        rst_n = 0; en = 1; idle(); instAddr = 0; pclData = 0;
        repeat (2) tick();
        n_cmp++;
        if (PCOut !== 9'h1FF || flushOut !== 1'b0) begin
            n_err++; $display("FAIL reset_state: pc=%h flush=%b want pc=1ff flush=0", PCOut, flushOut);
        end
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (PCOut !== exp_pc[i] || flushOut !== 1'b0) begin
                n_err++;
                $display("FAIL reset_incr%0d: pc=%h flush=%b want pc=%h flush=0",
                         i, PCOut, flushOut, exp_pc[i]);
            end
        end
    endtask

    task automatic test_goto();
        gotoEn = 1; instAddr = 9'h010; tick();
        gotoEn = 1; instAddr = 9'h1A5; tick(); idle();
        n_cmp++;
        if (PCOut !== 9'h1A5 || flushOut !== 1'b1) begin
            n_err++; $display("FAIL goto: pc=%h flush=%b want pc=1a5 flush=1", PCOut, flushOut);
        end
        tick();
        n_cmp++;
        if (PCOut !== 9'h1A6 || flushOut !== 1'b0) begin
            n_err++; $display("FAIL goto_after: pc=%h flush=%b want pc=1a6 flush=0", PCOut, flushOut);
        end
    endtask

    task automatic test_call_ret();
        gotoEn = 1; instAddr = 9'h020; tick(); idle();
        callEn = 1; instAddr = 9'h1C3; tick(); idle();
        n_cmp++;
        if (PCOut !== 9'h0C3 || flushOut !== 1'b1) begin
            n_err++; $display("FAIL call: pc=%h flush=%b want pc=0c3 flush=1", PCOut, flushOut);
        end
        repeat (2) tick();
        n_cmp++;
        if (PCOut !== 9'h0C5 || flushOut !== 1'b0) begin
            n_err++; $display("FAIL call_incr: pc=%h flush=%b want pc=0c5 flush=0", PCOut, flushOut);
        end
        retEn = 1; tick(); idle();
        n_cmp++;
        if (PCOut !== 9'h021 || flushOut !== 1'b1) begin
            n_err++; $display("FAIL ret: pc=%h flush=%b want pc=021 flush=1", PCOut, flushOut);
        end
        tick();
        n_cmp++;
        if (PCOut !== 9'h022 || flushOut !== 1'b0) begin
            n_err++; $display("FAIL ret_after: pc=%h flush=%b want pc=022 flush=0", PCOut, flushOut);
        end
    endtask

    task automatic test_nested_overflow();
        logic [8:0] exp_ret[3] = '{9'h078, 9'h043, 9'h043};
        gotoEn = 1; instAddr = 9'h005; tick(); idle();
        callEn = 1; instAddr = 9'h042; tick();
        callEn = 1; instAddr = 9'h077; tick();
`ifdef PC_STACK_ERR_EN
        n_cmp++;
        if (stackErr !== 1'b0) begin
            n_err++; $display("FAIL err_two_calls: err=%b want 0", stackErr);
        end
`endif
        callEn = 1; instAddr = 9'h0AA; tick(); idle();
        n_cmp++;
        if (PCOut !== 9'h0AA) begin
            n_err++; $display("FAIL call3: pc=%h want 0aa", PCOut);
        end
`ifdef PC_STACK_ERR_EN
        n_cmp++;
        if (stackErr !== 1'b1) begin
            n_err++; $display("FAIL err_overflow: err=%b want 1", stackErr);
        end
`endif
        retEn = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (PCOut !== exp_ret[i] || flushOut !== 1'b1) begin
                n_err++;
                $display("FAIL nested_ret%0d: pc=%h flush=%b want pc=%h flush=1",
                         i, PCOut, flushOut, exp_ret[i]);
            end
        end
        idle();
`ifdef PC_STACK_ERR_EN
        n_cmp++;
        if (stackErr !== 1'b1) begin
            n_err++; $display("FAIL err_sticky: err=%b want 1", stackErr);
        end
`endif
    endtask

    task automatic test_priority();
        gotoEn = 1; instAddr = 9'h032; tick(); idle();
        callEn = 1; instAddr = 9'h050; tick(); idle();
        retEn = 1; callEn = 1; gotoEn = 1; pclWrEn = 1; instAddr = 9'h111; pclData = 8'h44;
        tick(); idle();
        n_cmp++;
        if (PCOut !== 9'h033) begin
            n_err++; $display("FAIL prio_ret: pc=%h want 033", PCOut);
        end
        callEn = 1; gotoEn = 1; pclWrEn = 1; instAddr = 9'h1E1; tick(); idle();
        n_cmp++;
        if (PCOut !== 9'h0E1) begin
            n_err++; $display("FAIL prio_call: pc=%h want 0e1", PCOut);
        end
        gotoEn = 1; pclWrEn = 1; instAddr = 9'h150; pclData = 8'h12; tick(); idle();
        n_cmp++;
        if (PCOut !== 9'h150) begin
            n_err++; $display("FAIL prio_goto: pc=%h want 150", PCOut);
        end
        pclWrEn = 1; pclData = 8'hFE; tick(); idle();
        n_cmp++;
        if (PCOut !== 9'h0FE || flushOut !== 1'b1) begin
            n_err++; $display("FAIL pcl_write: pc=%h flush=%b want pc=0fe flush=1", PCOut, flushOut);
        end
    endtask

    task automatic test_en_hold();
        gotoEn = 1; instAddr = 9'h100; tick();
        en = 0; instAddr = 9'h055; callEn = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (PCOut !== 9'h100 || flushOut !== 1'b1) begin
                n_err++;
                $display("FAIL en_hold%0d: pc=%h flush=%b want pc=100 flush=1", i, PCOut, flushOut);
            end
        end
        idle(); en = 1; tick();
        n_cmp++;
        if (PCOut !== 9'h101 || flushOut !== 1'b0) begin
            n_err++; $display("FAIL en_resume: pc=%h flush=%b want pc=101 flush=0", PCOut, flushOut);
        end
    endtask

    task automatic test_async_reset();
        callEn = 1; instAddr = 9'h066; tick(); idle();
        #2 rst_n = 0; #1;
        n_cmp++;
        if (PCOut !== 9'h1FF || flushOut !== 1'b0) begin
            n_err++; $display("FAIL async_reset: pc=%h flush=%b want pc=1ff flush=0", PCOut, flushOut);
        end
`ifdef PC_STACK_ERR_EN
        n_cmp++;
        if (stackErr !== 1'b0) begin
            n_err++; $display("FAIL err_reset: err=%b want 0", stackErr);
        end
`endif
        #1 rst_n = 1;
        tick();
        n_cmp++;
        if (PCOut !== 9'h000) begin
            n_err++; $display("FAIL reset_wrap: pc=%h want 000", PCOut);
        end
        gotoEn = 1; instAddr = 9'h1FF; tick(); idle(); tick();
        n_cmp++;
        if (PCOut !== 9'h000) begin
            n_err++; $display("FAIL wrap_1ff: pc=%h want 000", PCOut);
        end
        // Stack was cleared by reset, so an underflowing return lands on 0.
        gotoEn = 1; instAddr = 9'h0AB; tick(); idle();
        retEn = 1; tick(); idle();
        n_cmp++;
        if (PCOut !== 9'h000 || flushOut !== 1'b1) begin
            n_err++; $display("FAIL underflow_ret: pc=%h flush=%b want pc=000 flush=1", PCOut, flushOut);
        end
`ifdef PC_STACK_ERR_EN
        n_cmp++;
        if (stackErr !== 1'b1) begin
            n_err++; $display("FAIL err_underflow: err=%b want 1", stackErr);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_goto();
        test_call_ret();
        test_nested_overflow();
        test_priority();
        test_en_hold();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
